// File: rtl/multi_port_g_aetcam.sv
// multi_port_g_aetcam
//   Flip-flop based ternary CAM with NPORTS independent write/search ports.
//   Every entry holds a pattern, a don't-care mask (1 = ignore bit) and a
//   valid bit. Writes and erases land at the clock edge. When several ports
//   target the same entry in one cycle, the lowest-index port wins. Each
//   port has its own two-stage search pipeline: stage 1 registers the match
//   lines, and stage 2 registers the priority-encoded result. A registered
//   counter tracks how many entries are valid.
//
// Ports (per-port fields are packed [NPORTS-1:0][..]):
//   clk, rst      clock and synchronous active-high reset
//   wEn, wErase   write request, and erase instead of write
//   wAddr         target entry
//   wPatt, wMask  stored pattern and mask
//   sValid, mPatt search request and key
//   mValid        result valid, two cycles after sValid
//   match, mAddr  any hit, and the lowest-index hitting entry
//   mMulti        two or more entries hit
//   occupancy     number of valid entries, 0..DEPTH

// Per-port search lane: stage 1 holds the match lines, stage 2 holds the result.
module multi_port_g_aetcam_lane #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  input  logic [DEPTH-1:0] ml_i,
  output logic             m_valid_o,
  output logic             match_o,
  output logic [AW-1:0]    m_addr_o,
  output logic             m_multi_o
);
  localparam int STAGES = 2;

  logic [STAGES:0]  vld_pipe;
  logic [DEPTH-1:0] ml_q;
  logic             match_q, multi_q;
  logic [AW-1:0]    addr_q;
  logic             hit_d, multi_d;
  logic [AW-1:0]    addr_d;

  assign vld_pipe[0] = s_valid_i;

  always_comb begin
    addr_d = '0;
    // Scan downward so that the lowest set index is the last assignment.
    for (int i = DEPTH-1; i >= 0; i--)
      if (ml_q[i]) addr_d = AW'(i);
    hit_d   = |ml_q;
    // Clearing the lowest set bit leaves something only if two or more bits are set.
    multi_d = |(ml_q & (ml_q - DEPTH'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      ml_q               <= '0;
      match_q            <= 1'b0;
      addr_q             <= '0;
      multi_q            <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      ml_q               <= s_valid_i ? ml_i : '0;
      // Without a valid search the result fields are forced to zero, not held.
      match_q            <= vld_pipe[1] & hit_d;
      addr_q             <= vld_pipe[1] ? addr_d : '0;
      multi_q            <= vld_pipe[1] & multi_d;
    end
  end

  assign m_valid_o = vld_pipe[STAGES];
  assign match_o   = match_q;
  assign m_addr_o  = addr_q;
  assign m_multi_o = multi_q;
endmodule

module multi_port_g_aetcam #(
  parameter  int DEPTH  = 64,
  parameter  int WIDTH  = 36,
  parameter  int NPORTS = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            wEn,
  input  logic [NPORTS-1:0]            wErase,
  input  logic [NPORTS-1:0][AW-1:0]    wAddr,
  input  logic [NPORTS-1:0][WIDTH-1:0] wPatt,
  input  logic [NPORTS-1:0][WIDTH-1:0] wMask,
  input  logic [NPORTS-1:0]            sValid,
  input  logic [NPORTS-1:0][WIDTH-1:0] mPatt,
  output logic [NPORTS-1:0]            mValid,
  output logic [NPORTS-1:0]            match,
  output logic [NPORTS-1:0][AW-1:0]    mAddr,
  output logic [NPORTS-1:0]            mMulti,
  output logic [AW:0]                  occupancy
);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [DEPTH-1:0][WIDTH-1:0] patt_q, mask_q;
  logic [DEPTH-1:0]            vld_q;
  logic [AW:0]                 occ_q, occ_d;

  // Resolved write per entry, after lowest-port-wins arbitration.
  logic [DEPTH-1:0]            win_en, win_erase;
  logic [DEPTH-1:0][WIDTH-1:0] win_patt, win_mask;
  logic [AW:0]                 inc, dec;
  logic [AW+1:0]               occ_sum;

  logic [NPORTS-1:0][DEPTH-1:0] ml;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      win_en[i]    = 1'b0;
      win_erase[i] = 1'b0;
      win_patt[i]  = '0;
      win_mask[i]  = '0;
      // Walk ports from the highest index down, so the lowest port overrides.
      for (int p = NPORTS-1; p >= 0; p--) begin
        if (wEn[p] && wAddr[p] == AW'(i)) begin
          win_en[i]    = 1'b1;
          win_erase[i] = wErase[p];
          win_patt[i]  = wPatt[p];
          win_mask[i]  = wMask[p];
        end
      end
    end
  end

  // Only real valid-bit transitions move the count.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (win_en[i] && !win_erase[i] && !vld_q[i]) inc = inc + ONE;
      if (win_en[i] &&  win_erase[i] &&  vld_q[i]) dec = dec + ONE;
    end
    occ_sum = {1'b0, occ_q} + {1'b0, inc} - {1'b0, dec};
    // The count tracks the valid bits exactly. This clamp only guards the range.
    if (occ_sum > (AW+2)'(DEPTH)) occ_d = (AW+1)'(DEPTH);
    else                          occ_d = occ_sum[AW:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      patt_q <= '0;
      mask_q <= '0;
      vld_q  <= '0;
      occ_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (win_en[i]) begin
          if (win_erase[i]) begin
            vld_q[i]  <= 1'b0;
          end else begin
            patt_q[i] <= win_patt[i];
            mask_q[i] <= win_mask[i];
            vld_q[i]  <= 1'b1;
          end
        end
      end
      occ_q <= occ_d;
    end
  end

  // Match lines use the current array contents, so a same-cycle write is not seen.
  always_comb begin
    for (int p = 0; p < NPORTS; p++)
      for (int i = 0; i < DEPTH; i++)
        ml[p][i] = vld_q[i] && (((patt_q[i] ^ mPatt[p]) & ~mask_q[i]) == '0);
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_lane
    multi_port_g_aetcam_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .s_valid_i (sValid[p]),
      .ml_i      (ml[p]),
      .m_valid_o (mValid[p]),
      .match_o   (match[p]),
      .m_addr_o  (mAddr[p]),
      .m_multi_o (mMulti[p])
    );
  end

  assign occupancy = occ_q;
endmodule

// File: tb/tb_multi_port_g_aetcam.sv
module tb_multi_port_g_aetcam;
  localparam int DEPTH = 64, WIDTH = 36, NP = 2, AW = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0]           wEn, wErase, sValid;
  logic [NP-1:0][AW-1:0]   wAddr;
  logic [NP-1:0][WIDTH-1:0] wPatt, wMask, mPatt;
  logic [NP-1:0]           mValid, match, mMulti;
  logic [NP-1:0][AW-1:0]   mAddr;
  logic [AW:0]             occupancy;

  multi_port_g_aetcam #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NPORTS(NP)) dut (
    .clk(clk), .rst(rst), .wEn(wEn), .wErase(wErase), .wAddr(wAddr),
    .wPatt(wPatt), .wMask(wMask), .sValid(sValid), .mPatt(mPatt),
    .mValid(mValid), .match(match), .mAddr(mAddr), .mMulti(mMulti),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  typedef struct {
    int              port;
    logic [WIDTH-1:0] key;
    logic            exp_m;
    int              exp_a;
    logic            exp_mu;
  } vec_t;
  vec_t tbl[7];

  task automatic tick; @(posedge clk); #1; endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle;
    wEn = '0; wErase = '0; wAddr = '0; wPatt = '0; wMask = '0;
    sValid = '0; mPatt = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [WIDTH-1:0] pt,
                    input logic [WIDTH-1:0] mk, input logic er);
    wEn[p] = 1'b1; wErase[p] = er; wAddr[p] = AW'(a); wPatt[p] = pt; wMask[p] = mk;
  endtask

  task automatic wr1(input int p, input int a, input logic [WIDTH-1:0] pt,
                     input logic [WIDTH-1:0] mk, input logic er);
    wr(p, a, pt, mk, er); tick; idle;
  endtask

  task automatic search(input int p, input logic [WIDTH-1:0] key, input logic em,
                        input int ea, input logic emu, input string nm);
    sValid[p] = 1'b1; mPatt[p] = key; tick;
    sValid = '0; tick;
    chk({nm, ".mValid"}, 64'(mValid[p]), 64'(1));
    chk({nm, ".other_mValid"}, 64'(mValid[1-p]), 64'(0));
    chk({nm, ".match"}, 64'(match[p]), 64'(em));
    chk({nm, ".mAddr"}, 64'(mAddr[p]), 64'(ea));
    chk({nm, ".mMulti"}, 64'(mMulti[p]), 64'(emu));
  endtask

  initial begin
    // Entry 5: 0xABC/0x00F, entry 9: 0xAB0/0x0FF
    tbl[0] = '{0, 36'hAB7,   1'b1, 5, 1'b1};
    tbl[1] = '{1, 36'hAB7,   1'b1, 5, 1'b1};
    tbl[2] = '{0, 36'hABF,   1'b1, 5, 1'b1};
    tbl[3] = '{1, 36'hA00,   1'b1, 9, 1'b0};
    tbl[4] = '{0, 36'hAC0,   1'b1, 9, 1'b0};
    tbl[5] = '{1, 36'hBB7,   1'b0, 0, 1'b0};
    tbl[6] = '{0, 36'hF0AB7, 1'b0, 0, 1'b0};

    idle; rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("reset.mValid", 64'(mValid), 64'(0));
    chk("reset.occupancy", 64'(occupancy), 64'(0));
    search(0, '0, 1'b0, 0, 1'b0, "empty");
    chk("empty.occupancy", 64'(occupancy), 64'(0));
    tick;
    chk("forced.mValid", 64'(mValid[0]), 64'(0));
    chk("forced.match", 64'(match[0]), 64'(0));

    // Ternary hits and priority
    wr(0, 5, 36'hABC, 36'h00F, 1'b0);
    wr(1, 9, 36'hAB0, 36'h0FF, 1'b0);
    tick; idle;
    chk("tern.occupancy", 64'(occupancy), 64'(2));
    for (int k = 0; k < 7; k++)
      search(tbl[k].port, tbl[k].key, tbl[k].exp_m, tbl[k].exp_a, tbl[k].exp_mu,
             $sformatf("tbl%0d", k));
    wr1(0, 5, '0, '0, 1'b1);
    chk("erase5.occupancy", 64'(occupancy), 64'(1));
    search(0, 36'hAB7, 1'b1, 9, 1'b0, "erase5");

    // A write in cycle t is invisible to a search in cycle t, visible in t+1.
    wr(1, 3, 36'h123, '0, 1'b0);
    sValid[0] = 1'b1; mPatt[0] = 36'h123;
    tick;
    wEn = '0;
    tick;
    chk("order1.mValid", 64'(mValid[0]), 64'(1));
    chk("order1.match", 64'(match[0]), 64'(0));
    sValid = '0;
    tick;
    chk("order2.mValid", 64'(mValid[0]), 64'(1));
    chk("order2.match", 64'(match[0]), 64'(1));
    chk("order2.mAddr", 64'(mAddr[0]), 64'(3));
    idle;
    chk("order.occupancy", 64'(occupancy), 64'(2));

    // Same-address conflict: port 0 wins
    wr(0, 7, 36'h111, '0, 1'b0);
    wr(1, 7, 36'h222, '0, 1'b0);
    tick; idle;
    chk("conflict.occupancy", 64'(occupancy), 64'(3));
    search(1, 36'h111, 1'b1, 7, 1'b0, "conflict_win");
    search(0, 36'h222, 1'b0, 0, 1'b0, "conflict_lose");

    // Fill the whole array using both ports
    for (int k = 0; k < DEPTH/2; k++) begin
      wr(0, 2*k,   36'h100 + 36'(2*k),   '0, 1'b0);
      wr(1, 2*k+1, 36'h100 + 36'(2*k+1), '0, 1'b0);
      tick;
    end
    idle;
    chk("fill.occupancy", 64'(occupancy), 64'(DEPTH));
    search(0, 36'h100 + 36'd42, 1'b1, 42, 1'b0, "fill42");
    wr1(1, 0, 36'h100, '0, 1'b0);
    chk("rewrite.occupancy", 64'(occupancy), 64'(DEPTH));
    wr(0, 0, '0, '0, 1'b1);
    wr(1, 1, '0, '0, 1'b1);
    tick; idle;
    chk("erase01.occupancy", 64'(occupancy), 64'(DEPTH-2));
    wr1(0, 0, '0, '0, 1'b1);
    chk("reerase.occupancy", 64'(occupancy), 64'(DEPTH-2));
    // Erase on port 0 beats a write on port 1 to the same entry
    wr(0, 0, '0, '0, 1'b1);
    wr(1, 0, 36'h100, '0, 1'b0);
    tick; idle;
    chk("erase_wins.occupancy", 64'(occupancy), 64'(DEPTH-2));
    search(1, 36'h100, 1'b0, 0, 1'b0, "erase_wins");
    search(0, 36'h101, 1'b0, 0, 1'b0, "erased1");
    search(1, 36'h102, 1'b1, 2, 1'b0, "entry2");

    // Reset mid-flight, with a write held during reset
    sValid = '1; mPatt[0] = 36'h102; mPatt[1] = 36'h102;
    tick; tick;
    rst = 1'b1;
    wr(0, 20, 36'h555, '0, 1'b0);
    tick;
    idle; rst = 1'b0;
    chk("rst_t1.mValid", 64'(mValid), 64'(0));
    tick;
    chk("rst_t2.mValid", 64'(mValid), 64'(0));
    chk("rst.occupancy", 64'(occupancy), 64'(0));
    search(0, 36'h102, 1'b0, 0, 1'b0, "post_rst");
    search(1, 36'h555, 1'b0, 0, 1'b0, "rst_write_ignored");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
